// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flex
//  Description : Single-clock parametrised FIFO with occupancy count,
//                almost-full / almost-empty thresholds, sticky overflow and
//                underflow flags, synchronous flush and an optional
//                first-word-fall-through (FWFT) read mode.
//
//  Ports
//    clk          : clock, all state updates on the rising edge
//    rst          : asynchronous active-high reset
//    flush        : synchronous clear of contents and error flags
//    write_en     : write request, data_in captured when not full
//    data_in      : write data
//    read_en      : read request (pop), accepted when not empty
//    data_out     : read data (registered, or fall-through when FWFT=1)
//    empty / full : occupancy == 0 / occupancy == DEPTH
//    almost_full  : count >= AFULL_THRESH
//    almost_empty : count <= AEMPTY_THRESH
//    count        : current occupancy 0..DEPTH
//    overflow     : sticky, write attempted while full
//    underflow    : sticky, read attempted while empty
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int DATA_LEN      = 32,
    parameter int ADDR_LEN      = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_LEN) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                write_en,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                read_en,
    output logic [DATA_LEN-1:0] data_out,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_LEN:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int              c_DEPTH     = 1 << ADDR_LEN;
    localparam logic [ADDR_LEN:0] c_DEPTH_CNT = (ADDR_LEN+1)'(c_DEPTH);
    localparam logic [ADDR_LEN:0] c_AFULL     = (ADDR_LEN+1)'(AFULL_THRESH);
    localparam logic [ADDR_LEN:0] c_AEMPTY    = (ADDR_LEN+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_LEN:0] c_ONE       = (ADDR_LEN+1)'(1);

    // Storage (not reset)
    logic [DATA_LEN-1:0] r_mem [0:c_DEPTH-1];

    // Registered state
    logic [ADDR_LEN:0] r_wptr_q;
    logic [ADDR_LEN:0] r_rptr_q;
    logic [ADDR_LEN:0] r_count_q;
    logic              r_empty_q;
    logic              r_full_q;
    logic              r_afull_q;
    logic              r_aempty_q;
    logic              r_ovf_q;
    logic              r_unf_q;

    // Next-state values
    logic [ADDR_LEN:0] w_wptr_d;
    logic [ADDR_LEN:0] w_rptr_d;
    logic [ADDR_LEN:0] w_count_d;
    logic              w_empty_d;
    logic              w_full_d;
    logic              w_afull_d;
    logic              w_aempty_d;
    logic              w_ovf_d;
    logic              w_unf_d;

    logic              w_wacc;
    logic              w_racc;
    logic [DATA_LEN-1:0] w_head;

    // Accepts use only the registered flags. Flush suppresses both so that a
    // write in the flush cycle never lands in memory.
    assign w_wacc = write_en & ~r_full_q  & ~flush;
    assign w_racc = read_en  & ~r_empty_q & ~flush;
    assign w_head = r_mem[r_rptr_q[ADDR_LEN-1:0]];

    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        w_ovf_d   = r_ovf_q;
        w_unf_d   = r_unf_q;

        if (flush) begin
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_count_d = '0;
            w_ovf_d   = 1'b0;
            w_unf_d   = 1'b0;
        end else begin
            if (w_wacc) begin
                w_wptr_d = r_wptr_q + c_ONE;
            end
            if (w_racc) begin
                w_rptr_d = r_rptr_q + c_ONE;
            end
            case ({w_wacc, w_racc})
                2'b10:   w_count_d = r_count_q + c_ONE;
                2'b01:   w_count_d = r_count_q - c_ONE;
                default: w_count_d = r_count_q;
            endcase
            w_ovf_d = r_ovf_q | (write_en & r_full_q);
            w_unf_d = r_unf_q | (read_en  & r_empty_q);
        end

        // Flags come from the next-state count so they are plain flops.
        w_empty_d  = (w_count_d == '0);
        w_full_d   = (w_count_d == c_DEPTH_CNT);
        w_afull_d  = (w_count_d >= c_AFULL);
        w_aempty_d = (w_count_d <= c_AEMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr_q   <= '0;
            r_rptr_q   <= '0;
            r_count_q  <= '0;
            r_empty_q  <= 1'b1;
            r_full_q   <= 1'b0;
            r_afull_q  <= 1'b0;
            r_aempty_q <= 1'b1;
            r_ovf_q    <= 1'b0;
            r_unf_q    <= 1'b0;
        end else begin
            r_wptr_q   <= w_wptr_d;
            r_rptr_q   <= w_rptr_d;
            r_count_q  <= w_count_d;
            r_empty_q  <= w_empty_d;
            r_full_q   <= w_full_d;
            r_afull_q  <= w_afull_d;
            r_aempty_q <= w_aempty_d;
            r_ovf_q    <= w_ovf_d;
            r_unf_q    <= w_unf_d;
        end
    end

    // Memory write; a reset coinciding with an edge aborts the write.
    always_ff @(posedge clk) begin
        if (w_wacc && !rst) begin
            r_mem[r_wptr_q[ADDR_LEN-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry falls through; forced to zero while empty so the
            // output is defined at reset and never shows stale storage.
            assign data_out = r_empty_q ? '0 : w_head;
        end else begin : g_std
            logic [DATA_LEN-1:0] r_dout_q;
            logic [DATA_LEN-1:0] w_dout_d;

            always_comb begin
                w_dout_d = r_dout_q;
                if (w_racc) begin
                    w_dout_d = w_head;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout_q <= '0;
                end else begin
                    r_dout_q <= w_dout_d;
                end
            end

            assign data_out = r_dout_q;
        end
    endgenerate

    assign empty        = r_empty_q;
    assign full         = r_full_q;
    assign almost_full  = r_afull_q;
    assign almost_empty = r_aempty_q;
    assign count        = r_count_q;
    assign overflow     = r_ovf_q;
    assign underflow    = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_flex
//  Description : Self-checking bench for sync_fifo_flex. Two instances
//                (FWFT=0 and FWFT=1, ADDR_LEN=3) share one stimulus stream
//                and are compared every cycle against a queue-based model,
//                with directed scenarios followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flex;

    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int DEPTH  = 1 << AW;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          write_en;
    logic [DW-1:0] data_in;
    logic          read_en;

    logic [DW-1:0] dout_w  [2];
    logic [AW:0]   count_w [2];
    logic [1:0]    empty_w, full_w, afull_w, aempty_w, ovf_w, unf_w;

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    // Behavioural model
    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dout0;

    always #5 clk = ~clk;

    sync_fifo_flex #(
        .DATA_LEN(DW), .ADDR_LEN(AW), .FWFT(0),
        .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en),
        .data_in(data_in), .read_en(read_en), .data_out(dout_w[0]),
        .empty(empty_w[0]), .full(full_w[0]), .almost_full(afull_w[0]),
        .almost_empty(aempty_w[0]), .count(count_w[0]),
        .overflow(ovf_w[0]), .underflow(unf_w[0])
    );

    sync_fifo_flex #(
        .DATA_LEN(DW), .ADDR_LEN(AW), .FWFT(1),
        .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en),
        .data_in(data_in), .read_en(read_en), .data_out(dout_w[1]),
        .empty(empty_w[1]), .full(full_w[1]), .almost_full(afull_w[1]),
        .almost_empty(aempty_w[1]), .count(count_w[1]),
        .overflow(ovf_w[1]), .underflow(unf_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout0 = '0;
    endtask

    // One clock of FIFO semantics, applied to the values sampled at the edge.
    task automatic model_edge();
        bit was_full;
        bit was_empty;
        if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (write_en && was_full)  m_ovf = 1'b1;
            if (read_en  && was_empty) m_unf = 1'b1;
            if (read_en  && !was_empty) m_dout0 = mq.pop_front();
            if (write_en && !was_full)  mq.push_back(data_in);
        end
    endtask

    task automatic step(input logic we, input logic [DW-1:0] d,
                        input logic re, input logic fl);
        write_en = we;
        data_in  = d;
        read_en  = re;
        flush    = fl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic compare_all();
        int n;
        logic [DW-1:0] exp_dout;
        logic [AW:0]   pdiff;
        n = mq.size();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("count[%0d]", i),  32'(count_w[i]),  n);
            chk($sformatf("empty[%0d]", i),  32'(empty_w[i]),  32'(n == 0));
            chk($sformatf("full[%0d]", i),   32'(full_w[i]),   32'(n == DEPTH));
            chk($sformatf("afull[%0d]", i),  32'(afull_w[i]),  32'(n >= AFULL));
            chk($sformatf("aempty[%0d]", i), 32'(aempty_w[i]), 32'(n <= AEMPTY));
            chk($sformatf("ovf[%0d]", i),    32'(ovf_w[i]),    32'(m_ovf));
            chk($sformatf("unf[%0d]", i),    32'(unf_w[i]),    32'(m_unf));
            if (i == 0) exp_dout = m_dout0;
            else        exp_dout = (n == 0) ? '0 : mq[0];
            chk($sformatf("dout[%0d]", i),   32'(dout_w[i]),   32'(exp_dout));
        end
        // Pointer distance modulo 2*DEPTH must equal the occupancy.
        pdiff = dut0.r_wptr_q - dut0.r_rptr_q;
        chk("ptr_vs_count", 32'(pdiff), n);
    endtask

    always @(negedge clk) begin
        if (run) compare_all();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pw;
        int pr;
        rst = 1'b1; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b1;

        // Reset state
        chk("rst_count", 32'(count_w[0]), 0);
        chk("rst_empty", 32'(empty_w[0]), 1);
        chk("rst_aempty", 32'(aempty_w[0]), 1);
        chk("rst_dout0", 32'(dout_w[0]), 0);

        // Fill with 0x10..0x17, thresholds tracked along the way
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            chk("fill_count", 32'(count_w[0]), i + 1);
            chk("fill_afull", 32'(afull_w[0]), 32'((i + 1) >= 6));
            chk("fill_aempty", 32'(aempty_w[0]), 32'((i + 1) <= 1));
        end
        chk("fill_full", 32'(full_w[0]), 1);

        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_w[0]), 1);
        chk("ovf_count", 32'(count_w[0]), 8);

        // Drain, one-cycle read latency on the registered instance
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_dout0", 32'(dout_w[0]), 32'(8'h10 + k));
            chk("drain_afull", 32'(afull_w[0]), 32'((7 - k) >= 6));
        end
        chk("drain_empty", 32'(empty_w[0]), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("unf_set", 32'(unf_w[0]), 1);

        // Simultaneous read/write at count 4 across pointer wrap
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush_unf", 32'(unf_w[0]), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 8'(8'h30 + j), 1'b1, 1'b0);
            chk("rw_count", 32'(count_w[0]), 4);
        end
        chk("rw_last_dout0", 32'(dout_w[0]), 32'h3F);

        // Simultaneous read/write at full: only the read goes through
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk("full_again", 32'(full_w[0]), 1);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("rw_full_count", 32'(count_w[0]), 7);
        chk("rw_full_ovf", 32'(ovf_w[0]), 1);
        chk("rw_full_dout0", 32'(dout_w[0]), 32'h40);

        // FWFT: word visible the cycle after the write with no read
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("fwft_empty", 32'(empty_w[1]), 0);
        chk("fwft_dout1", 32'(dout_w[1]), 32'hAA);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(empty_w[1]), 1);

        // Flush wins over a same-cycle write
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_flush_count", 32'(count_w[0]), 5);
        chk("pre_flush_ovf", 32'(ovf_w[0]), 1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush_count", 32'(count_w[0]), 0);
        chk("flush_empty", 32'(empty_w[0]), 1);
        chk("flush_ovf", 32'(ovf_w[0]), 0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_flush_dout1", 32'(dout_w[1]), 32'h55);
        chk("post_flush_count", 32'(count_w[1]), 1);

        // Asynchronous reset in the middle of a write burst
        step(1'b1, 8'h81, 1'b0, 1'b0);
        step(1'b1, 8'h82, 1'b1, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_count", 32'(count_w[i]), 0);
            chk("arst_empty", 32'(empty_w[i]), 1);
            chk("arst_full", 32'(full_w[i]), 0);
            chk("arst_afull", 32'(afull_w[i]), 0);
            chk("arst_aempty", 32'(aempty_w[i]), 1);
            chk("arst_dout", 32'(dout_w[i]), 0);
            chk("arst_ovf", 32'(ovf_w[i]), 0);
        end
        @(negedge clk);
        #1 rst = 1'b0;

        // Randomized traffic in phases of varying write/read pressure
        for (int ph = 0; ph < 16; ph++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int c = 0; c < 100; c++) begin
                step(1'($urandom_range(0, 99) < pw), 8'($urandom),
                     1'($urandom_range(0, 99) < pr),
                     1'($urandom_range(0, 127) == 0));
            end
        end

        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
